// File: rtl/tc0260dar_pkg.sv
// ---------------------------------------------------------------------------
// tc0260dar_pkg
// Shared definitions for the TC0260DAR palette/DAC stage.
//   dar_state_t : RAM-port arbiter states (pixel lookups and CPU accesses)
//   DAR_IDX_W   : default palette index width (8K entries)
//   expand5/4   : channel widening to 8 bits (RGB555 and RGB444 decodes)
// Optional feature macro used by the blocks that import this package:
//   DAR_RGB444_EN
// ---------------------------------------------------------------------------
package tc0260dar_pkg;

    localparam int DAR_IDX_W = 13;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PIX_RD   = 3'd1,
        PIX_CAP  = 3'd2,
        CPU_RD   = 3'd3,
        CPU_WR   = 3'd4,
        CPU_DONE = 3'd5
    } dar_state_t;

    // Replicating the top bits makes 0x1F map to 0xFF and 0x00 to 0x00.
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    function automatic logic [7:0] expand4(input logic [3:0] c);
        return {c, c};
    endfunction

endpackage

// File: rtl/tc0260dar_expand.sv
// ---------------------------------------------------------------------------
// tc0260dar_expand
// Combinational palette word -> 8-bit R/G/B.
//   word_i    in  16  palette word
//   rgb444_i  in  1   format select, only honoured when DAR_RGB444_EN is defined
//   r_o/g_o/b_o out 8 expanded channels
// Default: RGB555, word = xBBBBBGGGGGRRRRR.
// DAR_RGB444_EN: rgb444_i=1 selects RRRRGGGGBBBBxxxx.
// ---------------------------------------------------------------------------
module tc0260dar_expand
    import tc0260dar_pkg::*;
(
    input  logic [15:0] word_i,
    input  logic        rgb444_i,
    output logic [7:0]  r_o,
    output logic [7:0]  g_o,
    output logic [7:0]  b_o
);

`ifdef DAR_RGB444_EN
    always_comb begin
        if (rgb444_i) begin
            r_o = expand4(word_i[15:12]);
            g_o = expand4(word_i[11:8]);
            b_o = expand4(word_i[7:4]);
        end else begin
            r_o = expand5(word_i[4:0]);
            g_o = expand5(word_i[9:5]);
            b_o = expand5(word_i[14:10]);
        end
    end
`else
    assign r_o = expand5(word_i[4:0]);
    assign g_o = expand5(word_i[9:5]);
    assign b_o = expand5(word_i[14:10]);

    // Bit 15 carries no colour in RGB555; the format pin stays for a fixed interface.
    logic unused_ok;
    assign unused_ok = ^{word_i[15], rgb444_i};
`endif

endmodule

// File: rtl/tc0260dar_palette.sv
// ---------------------------------------------------------------------------
// tc0260dar_palette
// Palette/DAC stage: looks up the per-pixel colour index in external
// single-port palette RAM and drives blanked 8-bit R/G/B one pixel later.
// The same RAM port serves 68000 reads/writes (CS edge, DTACK handshake);
// pixel lookups always take priority.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ce_pixel              pixel enable, one clk wide
//   SC, HBLn, VBLn        colour index and active-low blanks from the mixer
//   VA, Din, Dout         CPU word address, write data, read data
//   LDSn, UDSn, CSn, RW   CPU byte strobes, chip select, direction (1=read)
//   DACKn                 DTACK, active low (0 while CSn is high)
//   PA, PDin, PDout       palette RAM address, read data (1 clk after PA), write data
//   PWEUPn, PWELOn        palette RAM byte write enables, active low
//   rgb444                format select (DAR_RGB444_EN only)
//   R, G, B, HBLOn, VBLOn pixel colour and delayed blanks
// Optional feature macro: DAR_RGB444_EN (RGB444 decode path in the expander).
// ---------------------------------------------------------------------------
module tc0260dar_palette
    import tc0260dar_pkg::*;
#(
    parameter int IDX_W   = DAR_IDX_W,
    parameter int MIN_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pixel,
    input  logic [14:0]      SC,
    input  logic             HBLn,
    input  logic             VBLn,
    input  logic [IDX_W-1:0] VA,
    input  logic [15:0]      Din,
    output logic [15:0]      Dout,
    input  logic             LDSn,
    input  logic             UDSn,
    input  logic             CSn,
    input  logic             RW,
    output logic             DACKn,
    output logic [IDX_W-1:0] PA,
    input  logic [15:0]      PDin,
    output logic [15:0]      PDout,
    output logic             PWEUPn,
    output logic             PWELOn,
    input  logic             rgb444,
    output logic [7:0]       R,
    output logic [7:0]       G,
    output logic [7:0]       B,
    output logic             HBLOn,
    output logic             VBLOn
);

    // A pixel slot (3 clk) plus a CPU slot (2 clk) only interleave safely
    // when pixels are at least 4 clk apart.
    if (MIN_DIV < 4) begin : g_min_div_chk
        $error("tc0260dar_palette: MIN_DIV must be at least 4");
    end

    dar_state_t       state_q, state_d;
    logic [IDX_W-1:0] sc_q, pa_q, pa_d;
    logic             hbl_q, vbl_q, pix_pend_q, pix_req;
    logic [15:0]      col_q, dout_q;
    logic             csn_q, cs_fall, cs_rise, cpu_pend_q, cpu_go, cpu_rd_q, dtack_n_q;
    logic             pwe_up_n_q, pwe_up_n_d, pwe_lo_n_q, pwe_lo_n_d;
    logic [7:0]       r_q, g_q, b_q, exp_r, exp_g, exp_b;
    logic             hblo_q, vblo_q;

    assign pix_req = ce_pixel | pix_pend_q;
    assign cs_fall = csn_q & ~CSn;
    assign cs_rise = ~csn_q & CSn;
    // A request whose CSn has already risen is dropped, so an aborted write never reaches RAM.
    assign cpu_go  = cpu_pend_q & ~CSn;

    // ---------------- state register ----------------
    // NOTE: every clocked block uses <= so all registers see the pre-edge values of each other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next state ----------------
    // NOTE: each combinational block assigns defaults first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pix_req)     state_d = PIX_RD;
                else if (cpu_go) state_d = RW ? CPU_RD : CPU_WR;
            end
            PIX_RD:          state_d = PIX_CAP;
            PIX_CAP:         state_d = IDLE;
            CPU_RD, CPU_WR:  state_d = CPU_DONE;
            CPU_DONE:        state_d = pix_req ? PIX_RD : IDLE;
            default:         state_d = IDLE;
        endcase
    end

    // ---------------- RAM port outputs (registered, decoded from next state) ----------------
    always_comb begin
        pa_d       = pa_q;
        pwe_up_n_d = 1'b1;
        pwe_lo_n_d = 1'b1;
        unique case (state_d)
            // Entering PIX_RD on the ce_pixel edge itself means sc_q is not loaded yet.
            PIX_RD: pa_d = ce_pixel ? SC[IDX_W-1:0] : sc_q;
            CPU_RD: pa_d = VA;
            CPU_WR: begin
                pa_d       = VA;
                pwe_up_n_d = UDSn;
                pwe_lo_n_d = LDSn;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pa_q       <= '0;
            pwe_up_n_q <= 1'b1;
            pwe_lo_n_q <= 1'b1;
        end else begin
            pa_q       <= pa_d;
            pwe_up_n_q <= pwe_up_n_d;
            pwe_lo_n_q <= pwe_lo_n_d;
        end
    end

    // ---------------- pixel path ----------------
    tc0260dar_expand u_expand (
        .word_i   (col_q),
        .rgb444_i (rgb444),
        .r_o      (exp_r),
        .g_o      (exp_g),
        .b_o      (exp_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sc_q       <= '0;
            hbl_q      <= 1'b0;
            vbl_q      <= 1'b0;
            pix_pend_q <= 1'b0;
            col_q      <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            hblo_q     <= 1'b0;
            vblo_q     <= 1'b0;
        end else begin
            // Holds a pixel request while an in-flight CPU slot finishes.
            pix_pend_q <= pix_req && (state_d != PIX_RD);
            if (state_q == PIX_CAP) col_q <= PDin;
            if (ce_pixel) begin
                // Output the previous pixel (its colour is already in col_q), then latch this one.
                r_q    <= (hbl_q && vbl_q) ? exp_r : 8'd0;
                g_q    <= (hbl_q && vbl_q) ? exp_g : 8'd0;
                b_q    <= (hbl_q && vbl_q) ? exp_b : 8'd0;
                hblo_q <= hbl_q;
                vblo_q <= vbl_q;
                sc_q   <= SC[IDX_W-1:0];
                hbl_q  <= HBLn;
                vbl_q  <= VBLn;
            end
        end
    end

    // ---------------- CPU handshake ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // Starting "low" means a CSn already held low across reset is not seen as a new cycle.
            csn_q      <= 1'b0;
            cpu_pend_q <= 1'b0;
            cpu_rd_q   <= 1'b0;
            dtack_n_q  <= 1'b1;
            dout_q     <= '0;
        end else begin
            csn_q <= CSn;
            if (state_d == CPU_RD)      cpu_rd_q <= 1'b1;
            else if (state_d == CPU_WR) cpu_rd_q <= 1'b0;

            if (cs_fall)                              cpu_pend_q <= 1'b1;
            else if (cs_rise || state_q == CPU_DONE)  cpu_pend_q <= 1'b0;

            if (cs_rise) begin
                dtack_n_q <= 1'b1;
            end else if (state_q == CPU_DONE && !CSn) begin
                dtack_n_q <= 1'b0;
                if (cpu_rd_q) dout_q <= PDin;
            end
        end
    end

    assign DACKn  = CSn ? 1'b0 : dtack_n_q;
    assign Dout   = dout_q;
    assign PA     = pa_q;
    assign PDout  = Din;
    assign PWEUPn = pwe_up_n_q;
    assign PWELOn = pwe_lo_n_q;
    assign R      = r_q;
    assign G      = g_q;
    assign B      = b_q;
    assign HBLOn  = hblo_q;
    assign VBLOn  = vblo_q;

    // Index bits above IDX_W are ignored by design.
    logic unused_ok;
    assign unused_ok = ^SC;

endmodule

// File: tb/tb_tc0260dar_palette.sv
// ---------------------------------------------------------------------------
// tb_tc0260dar_palette
// Directed bench for tc0260dar_palette with a behavioural palette RAM
// (synchronous read, byte writes) and a pixel scoreboard: each pixel's
// palette word and blanks are queued when driven and compared one
// ce_pixel later. Honours DAR_RGB444_EN in its colour model.
// ---------------------------------------------------------------------------
module tb_tc0260dar_palette;

`ifdef DAR_RGB444_EN
    localparam bit HAS_444 = 1'b1;
`else
    localparam bit HAS_444 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, ce_pixel, HBLn, VBLn, LDSn, UDSn, CSn, RW, rgb444;
    logic [14:0] SC;
    logic [12:0] VA, PA;
    logic [15:0] Din, Dout, PDin, PDout;
    logic        DACKn, PWEUPn, PWELOn, HBLOn, VBLOn;
    logic [7:0]  R, G, B;

    logic [15:0] ram [0:8191];

    typedef struct {
        logic [15:0] word;
        logic        hbl;
        logic        vbl;
    } px_exp_t;

    px_exp_t exp_q[$];
    int      checks_total  = 0;
    int      checks_passed = 0;
    int      checks_failed = 0;

    tc0260dar_palette dut (
        .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .SC(SC), .HBLn(HBLn), .VBLn(VBLn),
        .VA(VA), .Din(Din), .Dout(Dout), .LDSn(LDSn), .UDSn(UDSn), .CSn(CSn), .RW(RW),
        .DACKn(DACKn), .PA(PA), .PDin(PDin), .PDout(PDout), .PWEUPn(PWEUPn), .PWELOn(PWELOn),
        .rgb444(rgb444), .R(R), .G(G), .B(B), .HBLOn(HBLOn), .VBLOn(VBLOn)
    );

    always #5 clk = ~clk;

    // Palette RAM: data for address PA appears on PDin one clk later.
    always @(posedge clk) begin
        if (!PWEUPn) ram[PA][15:8] <= PDout[15:8];
        if (!PWELOn) ram[PA][7:0]  <= PDout[7:0];
        PDin <= ram[PA];
    end

    function automatic logic [23:0] model_rgb(input logic [15:0] w, input logic f444);
        int r5, g5, b5;
        if (HAS_444 && f444)
            return {w[15:12], w[15:12], w[11:8], w[11:8], w[7:4], w[7:4]};
        r5 = int'(w) & 31;
        g5 = (int'(w) >> 5) & 31;
        b5 = (int'(w) >> 10) & 31;
        return {8'((r5 << 3) | (r5 >> 2)), 8'((g5 << 3) | (g5 >> 2)), 8'((b5 << 3) | (b5 >> 2))};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks_total++;
        assert (obs === expv) checks_passed++;
        else begin
            checks_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic fail_now(input string tag);
        checks_total++;
        checks_failed++;
        $error("FAIL %s: scoreboard empty, observed output with no expectation", tag);
    endtask

    task automatic backdoor(input logic [12:0] a, input logic [15:0] v);
        ram[a] <= v;
        @(negedge clk);
    endtask

    // Compare the DUT's current pixel outputs with the oldest queued pixel.
    task automatic pop_check(input string who);
        px_exp_t     e;
        logic [23:0] rgb;
        if (exp_q.size() == 0) begin
            fail_now(who);
            return;
        end
        e   = exp_q.pop_front();
        rgb = (e.hbl && e.vbl) ? model_rgb(e.word, rgb444) : 24'd0;
        check({who, "_r"},    {8'd0, R},      {8'd0, rgb[23:16]});
        check({who, "_g"},    {8'd0, G},      {8'd0, rgb[15:8]});
        check({who, "_b"},    {8'd0, B},      {8'd0, rgb[7:0]});
        check({who, "_hblo"}, {15'd0, HBLOn}, {15'd0, e.hbl});
        check({who, "_vblo"}, {15'd0, VBLOn}, {15'd0, e.vbl});
    endtask

    // Called at a negedge; drives one pixel, checks the previous one, keeps 5 clk spacing.
    task automatic pixel(input string who, input logic [14:0] sc, input logic h, input logic v);
        px_exp_t e;
        e.word = ram[sc[12:0]];
        e.hbl  = h;
        e.vbl  = v;
        exp_q.push_back(e);
        SC = sc; HBLn = h; VBLn = v; ce_pixel = 1'b1;
        @(negedge clk);
        ce_pixel = 1'b0;
        pop_check(who);
        repeat (4) @(negedge clk);
    endtask

    task automatic push_reset_entry();
        px_exp_t e;
        e.word = 16'h0000;
        e.hbl  = 1'b0;
        e.vbl  = 1'b0;
        exp_q.delete();
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  up_cnt, lo_cnt;
        bit  got, seen_va;

        reset = 1'b1; ce_pixel = 1'b0; SC = '0; HBLn = 1'b1; VBLn = 1'b1;
        VA = '0; Din = '0; LDSn = 1'b1; UDSn = 1'b1; CSn = 1'b1; RW = 1'b1; rgb444 = 1'b0;
        for (int i = 0; i < 8192; i++) ram[i] <= 16'h0000;
        repeat (3) @(negedge clk);
        ram[13'h123] <= 16'h7FFF;
        ram[13'h010] <= 16'h0421;
        ram[13'h040] <= 16'h1234;
        ram[13'h050] <= 16'h5555;
        ram[13'h060] <= 16'hF0A0;
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_r",      {8'd0, R},       16'h0000);
        check("rst_dout",   Dout,            16'h0000);
        check("rst_weup",   {15'd0, PWEUPn}, 16'h0001);
        check("rst_welo",   {15'd0, PWELOn}, 16'h0001);
        check("rst_hblo",   {15'd0, HBLOn},  16'h0000);
        check("rst_vblo",   {15'd0, VBLOn},  16'h0000);
        check("rst_dackn",  {15'd0, DACKn},  16'h0000);
        push_reset_entry();

        // White, then pure red from the same address (second one via an index with upper bits set)
        pixel("p1_reset_out", 15'h0123, 1'b1, 1'b1);
        backdoor(13'h123, 16'h001F);
        pixel("p2_white",     15'h6123, 1'b1, 1'b1);
        // Blanking
        pixel("p3_red_wrap",  15'h0010, 1'b0, 1'b1);
        pixel("p4_hblank",    15'h0010, 1'b1, 1'b1);
        pixel("p5_grey08",    15'h0010, 1'b1, 1'b0);
        pixel("p6_vblank",    15'h0123, 1'b1, 1'b1);

        // CPU upper-byte write to 0x040
        VA = 13'h040; Din = 16'hABCD; RW = 1'b0; UDSn = 1'b0; LDSn = 1'b1; CSn = 1'b0;
        up_cnt = 0; lo_cnt = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!PWEUPn) up_cnt++;
            if (!PWELOn) lo_cnt++;
            if (!DACKn) got = 1'b1;
        end
        check("wr_dtack_seen", {15'd0, got}, 16'h0001);
        check("wr_weup_pulses", 16'(up_cnt), 16'd1);
        check("wr_welo_pulses", 16'(lo_cnt), 16'd0);
        check("wr_ram_word", ram[13'h040], 16'hAB34);
        repeat (3) @(negedge clk);
        check("wr_dackn_held", {15'd0, DACKn}, 16'h0000);
        CSn = 1'b1; UDSn = 1'b1; RW = 1'b1;
        repeat (2) @(negedge clk);

        // Pixel and CPU read start on the same clk: pixel lookup first
        begin
            px_exp_t e;
            e.word = ram[13'h010]; e.hbl = 1'b1; e.vbl = 1'b1;
            exp_q.push_back(e);
        end
        SC = 15'h0010; HBLn = 1'b1; VBLn = 1'b1; ce_pixel = 1'b1;
        VA = 13'h040; RW = 1'b1; UDSn = 1'b0; LDSn = 1'b0; CSn = 1'b0;
        @(negedge clk);
        ce_pixel = 1'b0;
        pop_check("p7_red");
        check("rd_pa_pixel_first", {3'd0, PA}, 16'h0010);
        check("rd_dackn_wait", {15'd0, DACKn}, 16'h0001);
        got = 1'b0; seen_va = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (PA == 13'h040) seen_va = 1'b1;
            if (!DACKn) got = 1'b1;
        end
        check("rd_pa_cpu_after", {15'd0, seen_va}, 16'h0001);
        check("rd_dtack_seen", {15'd0, got}, 16'h0001);
        check("rd_dout", Dout, 16'hAB34);
        CSn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
        repeat (2) @(negedge clk);

        pixel("p8_grey08", 15'h0040, 1'b1, 1'b1);
        pixel("p9_ab34",   15'h0123, 1'b1, 1'b1);

        // Reset in the middle of a CPU write
        VA = 13'h050; Din = 16'h0000; RW = 1'b0; UDSn = 1'b0; LDSn = 1'b0; CSn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_we_active", {15'd0, PWELOn}, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wr_weup",  {15'd0, PWEUPn}, 16'h0001);
        check("rst_wr_welo",  {15'd0, PWELOn}, 16'h0001);
        check("rst_wr_dackn", {15'd0, DACKn},  16'h0001);
        check("rst_wr_rgb",   {R, G},          16'h0000);
        reset = 1'b0;
        up_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!PWEUPn || !PWELOn) up_cnt++;
        end
        check("rst_wr_no_we", 16'(up_cnt), 16'd0);
        check("rst_wr_dackn_after", {15'd0, DACKn}, 16'h0001);
        check("rst_wr_ram_kept", ram[13'h050], 16'h5555);
        CSn = 1'b1; RW = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
        @(negedge clk);
        push_reset_entry();

        // Format select: RGB444 decode with the macro, RGB555 otherwise
        rgb444 = 1'b1;
        pixel("p10_after_reset", 15'h0060, 1'b1, 1'b1);
        pixel("p11_f0a0",        15'h0123, 1'b1, 1'b1);
        if (HAS_444) check("fmt_444_r", {8'd0, R}, 16'h00FF);
        else         check("fmt_555_r", {8'd0, R}, 16'h0000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
